// File: rtl/key_debounce_array.sv
// key_debounce_array: per-channel two-flop sync, debounce filter, press/release/long-press pulses.
// Channel state is the registered key_level bit itself; any_pressed tracks it on the same edge.
module key_debounce_array #(
    parameter int N_KEYS   = 5,
    parameter int CNT_MAX  = 40000,
    parameter int LONG_MAX = 100000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] key,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] press_pulse,
    output logic [N_KEYS-1:0] release_pulse,
    output logic [N_KEYS-1:0] long_pulse,
    output logic              any_pressed
);
    localparam int CW = $clog2(CNT_MAX + 1);
    localparam int HW = $clog2(LONG_MAX + 1);

    logic [N_KEYS-1:0] acc;

    for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
        logic          s1, s2, lvl, pp, rp, lp, mis;
        logic [CW-1:0] cnt;
        logic [HW-1:0] hold;
        // s2 low means pressed, so a mismatch is s2 equal to the stable level
        assign mis    = s2 == lvl;
        assign acc[g] = mis && cnt == CW'(CNT_MAX - 1);
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                s1   <= 1'b1;
                s2   <= 1'b1;
                cnt  <= '0;
                lvl  <= 1'b0;
                pp   <= 1'b0;
                rp   <= 1'b0;
                lp   <= 1'b0;
                hold <= '0;
            end else begin
                s1   <= key[g];
                s2   <= s1;
                cnt  <= (mis && !acc[g]) ? cnt + CW'(1) : '0;
                lvl  <= lvl ^ acc[g];
                pp   <= acc[g] & ~lvl;
                rp   <= acc[g] & lvl;
                lp   <= !acc[g] && lvl && hold == HW'(LONG_MAX - 1);
                hold <= acc[g] ? '0 : (lvl && hold != HW'(LONG_MAX)) ? hold + HW'(1) : hold;
            end
        end
        assign key_level[g]     = lvl;
        assign press_pulse[g]   = pp;
        assign release_pulse[g] = rp;
        assign long_pulse[g]    = lp;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) any_pressed <= 1'b0;
        else      any_pressed <= |(key_level ^ acc);
    end
endmodule

// File: tb/tb_key_debounce_array.sv
// tb_key_debounce_array: random key stimulus with glitches and resets, checked against a run-length model.
module tb_key_debounce_array;
    localparam int NK = 4, CM = 4, LM = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic [NK-1:0] key;
    logic [NK-1:0] key_level, press_pulse, release_pulse, long_pulse;
    logic          any_pressed;

    key_debounce_array #(.N_KEYS(NK), .CNT_MAX(CM), .LONG_MAX(LM)) dut (
        .clk(clk), .rst(rst), .key(key), .key_level(key_level),
        .press_pulse(press_pulse), .release_pulse(release_pulse),
        .long_pulse(long_pulse), .any_pressed(any_pressed)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0, cyc = 0;
    int npress = 0, nlong = 0;
    bit p1[NK], p2[NK], lvl[NK], run_val[NK];
    int run_len[NK], press_t[NK];
    logic [NK-1:0] e_lvl, e_pr, e_rl, e_lg;
    logic          e_any;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d got %h exp %h", tag, cyc, got, exp);
        end
    endtask

    task automatic check_all();
        check("key_level", 32'(key_level), 32'(e_lvl));
        check("press_pulse", 32'(press_pulse), 32'(e_pr));
        check("release_pulse", 32'(release_pulse), 32'(e_rl));
        check("long_pulse", 32'(long_pulse), 32'(e_lg));
        check("any_pressed", 32'(any_pressed), 32'(e_any));
    endtask

    task automatic model_reset();
        for (int i = 0; i < NK; i++) begin
            p1[i] = 1; p2[i] = 1; lvl[i] = 0; run_val[i] = 1; run_len[i] = 0; press_t[i] = 0;
        end
        e_lvl = '0; e_pr = '0; e_rl = '0; e_lg = '0; e_any = 1'b0;
    endtask

    // A level is accepted once the synchronized pin has shown the opposite value for CM edges in a row;
    // a long press is exactly LM edges after acceptance while still held.
    task automatic model_step();
        cyc++;
        for (int i = 0; i < NK; i++) begin
            bit sync, flip;
            sync = p2[i]; p2[i] = p1[i]; p1[i] = key[i];
            if (sync == run_val[i]) run_len[i]++;
            else begin run_val[i] = sync; run_len[i] = 1; end
            flip = ((sync == 0) != lvl[i]) && run_len[i] >= CM;
            e_pr[i] = flip && !lvl[i];
            e_rl[i] = flip && lvl[i];
            e_lg[i] = lvl[i] && !flip && (cyc - press_t[i] == LM);
            if (e_pr[i]) begin press_t[i] = cyc; npress++; end
            if (e_lg[i]) nlong++;
            if (flip) lvl[i] = !lvl[i];
            e_lvl[i] = lvl[i];
        end
        e_any = |e_lvl;
    endtask

    int  dur[NK];
    bit  cur[NK];
    int  rst_len = 0;

    initial begin
        rst = 1'b0;
        key = '1;
        model_reset();
        for (int i = 0; i < NK; i++) begin dur[i] = 0; cur[i] = 1; end
        repeat (3) begin @(negedge clk); check_all(); end
        rst = 1'b1;
        for (int c = 0; c < 2000; c++) begin
            @(posedge clk);
            if (rst) model_step();
            @(negedge clk);
            check_all();
            if (c < 40) key = (c < 30) ? 4'b1010 : 4'b1111;
            else if (c < 52) key = 4'b0111;
            else begin
                for (int i = 0; i < NK; i++) begin
                    if (dur[i] == 0) begin
                        cur[i] = !cur[i];
                        dur[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(6, 30) : $urandom_range(1, 5);
                    end
                    dur[i]--;
                    key[i] = cur[i];
                end
            end
            if (rst && c > 60 && $urandom_range(0, 149) == 0) begin
                rst = 1'b0;
                model_reset();
                #1 check_all();
                rst_len = $urandom_range(1, 3);
            end else if (!rst) begin
                rst_len--;
                if (rst_len == 0) rst = 1'b1;
            end
        end
        check("press_seen", 32'(npress > 0), 32'd1);
        check("long_seen", 32'(nlong > 0), 32'd1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
